// File: rtl/ps2_keypad_matrix_if.sv
// Scancode input channel and key-event output channel of the PS/2 keypad matrix.
interface ps2_keypad_matrix_if #(
  parameter int KEY_W = 5
);
  logic             code_valid;
  logic [7:0]       code_data;
  logic             evt_valid;
  logic [KEY_W-1:0] evt_key;
  logic             evt_release;
  logic             evt_pop;
  logic             evt_overflow;

  modport master (
    output code_valid, code_data, evt_pop,
    input  evt_valid, evt_key, evt_release, evt_overflow
  );

  modport slave (
    input  code_valid, code_data, evt_pop,
    output evt_valid, evt_key, evt_release, evt_overflow
  );
endinterface

// File: rtl/ps2_keypad_matrix.sv
// PS/2 scancode decoder (F0/E0/E1 prefixes) driving a key matrix and a
// first-word fall-through queue of press/release events.
module ps2_keypad_matrix #(
  parameter int NUM_KEYS   = 16,
  parameter int KEY_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                res,
  input  logic                layout_sel,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] key_matrix,
  output logic                any_down,
  ps2_keypad_matrix_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK, S_PAUSE} state_t;

  state_t                state, state_nxt;
  logic [2:0]            skip, skip_nxt;
  logic                  layout_q, layout_chg;
  logic                  lk_en, lk_ext, lk_make;
  logic                  hit, changed;
  logic [4:0]            k5;
  logic [NUM_KEYS-1:0]   onehot, matrix_nxt;
  logic [KEY_W:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  full, do_push, do_pop;

  assign layout_chg = (layout_sel != layout_q);

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip;
    lk_en     = 1'b0;
    lk_ext    = 1'b0;
    lk_make   = 1'b1;
    if (bus.code_valid) begin
      unique case (state)
        S_IDLE: begin
          if (bus.code_data == 8'hF0)      state_nxt = S_BRK;
          else if (bus.code_data == 8'hE0) state_nxt = S_EXT;
          else if (bus.code_data == 8'hE1) begin
            state_nxt = S_PAUSE;
            skip_nxt  = 3'd7;
          end else lk_en = 1'b1;
        end
        S_BRK: begin
          lk_en = 1'b1; lk_make = 1'b0; state_nxt = S_IDLE;
        end
        S_EXT: begin
          if (bus.code_data == 8'hF0) state_nxt = S_EXT_BRK;
          else begin
            lk_en = 1'b1; lk_ext = 1'b1; state_nxt = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          lk_en = 1'b1; lk_ext = 1'b1; lk_make = 1'b0; state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          skip_nxt = skip - 3'd1;
          if (skip == 3'd1) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    // Clear and layout change both abort any partial sequence and drop the byte.
    if (clear || layout_chg) begin
      state_nxt = S_IDLE;
      lk_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= S_IDLE;
      skip  <= '0;
    end else begin
      state <= state_nxt;
      skip  <= skip_nxt;
    end
  end

  always_comb begin
    hit = 1'b0;
    k5  = '0;
    if (!lk_ext && !layout_q) begin
      case (bus.code_data)
        8'h22: {hit, k5} = {1'b1, 5'd0};
        8'h16: {hit, k5} = {1'b1, 5'd1};
        8'h1E: {hit, k5} = {1'b1, 5'd2};
        8'h26: {hit, k5} = {1'b1, 5'd3};
        8'h15: {hit, k5} = {1'b1, 5'd4};
        8'h1D: {hit, k5} = {1'b1, 5'd5};
        8'h24: {hit, k5} = {1'b1, 5'd6};
        8'h1C: {hit, k5} = {1'b1, 5'd7};
        8'h1B: {hit, k5} = {1'b1, 5'd8};
        8'h23: {hit, k5} = {1'b1, 5'd9};
        8'h1A: {hit, k5} = {1'b1, 5'd10};
        8'h21: {hit, k5} = {1'b1, 5'd11};
        8'h25: {hit, k5} = {1'b1, 5'd12};
        8'h2D: {hit, k5} = {1'b1, 5'd13};
        8'h2B: {hit, k5} = {1'b1, 5'd14};
        8'h2A: {hit, k5} = {1'b1, 5'd15};
        default: ;
      endcase
    end else if (!lk_ext) begin
      case (bus.code_data)
        8'h70: {hit, k5} = {1'b1, 5'd0};
        8'h69: {hit, k5} = {1'b1, 5'd1};
        8'h72: {hit, k5} = {1'b1, 5'd2};
        8'h7A: {hit, k5} = {1'b1, 5'd3};
        8'h6B: {hit, k5} = {1'b1, 5'd4};
        8'h73: {hit, k5} = {1'b1, 5'd5};
        8'h74: {hit, k5} = {1'b1, 5'd6};
        8'h6C: {hit, k5} = {1'b1, 5'd7};
        8'h75: {hit, k5} = {1'b1, 5'd8};
        8'h7D: {hit, k5} = {1'b1, 5'd9};
        8'h71: {hit, k5} = {1'b1, 5'd10};
        8'h79: {hit, k5} = {1'b1, 5'd11};
        8'h7B: {hit, k5} = {1'b1, 5'd12};
        8'h7C: {hit, k5} = {1'b1, 5'd13};
        default: ;
      endcase
    end else if (layout_q) begin
      case (bus.code_data)
        8'h4A: {hit, k5} = {1'b1, 5'd14};
        8'h5A: {hit, k5} = {1'b1, 5'd15};
        default: ;
      endcase
    end
    if (!lk_ext && NUM_KEYS == 20) begin
      case (bus.code_data)
        8'h76: {hit, k5} = {1'b1, 5'd16};
        8'h05: {hit, k5} = {1'b1, 5'd17};
        8'h06: {hit, k5} = {1'b1, 5'd18};
        8'h04: {hit, k5} = {1'b1, 5'd19};
        default: ;
      endcase
    end
  end

  // Events are generated only when the addressed matrix bit actually flips.
  always_comb begin
    onehot     = NUM_KEYS'(1) << k5;
    matrix_nxt = lk_make ? (key_matrix | onehot) : (key_matrix & ~onehot);
    changed    = lk_en && hit && (matrix_nxt != key_matrix);
  end

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign do_pop  = bus.evt_pop && (count != '0) && !clear;
  assign do_push = changed && (!full || do_pop);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      key_matrix       <= '0;
      layout_q         <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      bus.evt_overflow <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      layout_q <= layout_sel;
      if (clear) begin
        key_matrix       <= '0;
        wr_ptr           <= '0;
        rd_ptr           <= '0;
        count            <= '0;
        bus.evt_overflow <= 1'b0;
      end else begin
        if (layout_chg)   key_matrix <= '0;
        else if (changed) key_matrix <= matrix_nxt;
        if (do_push) begin
          mem[wr_ptr] <= {~lk_make, KEY_W'(k5)};
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        if (changed && !do_push) bus.evt_overflow <= 1'b1;
      end
    end
  end

  assign any_down                       = |key_matrix;
  assign bus.evt_valid                  = (count != '0);
  assign {bus.evt_release, bus.evt_key} = mem[rd_ptr];
endmodule
